button_pulse_gen: RTL

BUTTON_PULSE_GEN -- requirements
Module: button_pulse_gen

---
 rtl/button_pulse_gen.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/button_pulse_gen.sv
// button_pulse_gen: six-button synchronizer and debouncer with
// single-cycle press strobes and optional auto-repeat while held.
module button_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 7500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] btn_in,
   output logic [5:0] level_out,
   output logic [5:0] pulse_out,
   output logic       any_press
);

   localparam int CW   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                         REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TW   = $clog2(TMAX) + 1;

   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } state_t;

   logic [5:0]    sync1;
   logic [5:0]    sync2;
   logic [CW-1:0] cnt   [6];
   logic [5:0]    accept;
   logic [5:0]    rise;
   logic [5:0]    fall;
   state_t        state [6];
   logic [TW-1:0] timer [6];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
      end
   end

   // accept marks the edge on which level_out takes the new value
   always_comb begin
      accept = '0;
      for (int i = 0; i < 6; i++) begin
         accept[i] = (sync2[i] != level_out[i]) && (cnt[i] == DB_LAST);
      end
   end

   assign rise = accept & sync2;
   assign fall = accept & ~sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_out <= '0;
         for (int i = 0; i < 6; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (sync2[i] == level_out[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DB_LAST) begin
               cnt[i]       <= '0;
               level_out[i] <= sync2[i];
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // release is checked first so it overrides a coinciding repeat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulse_out <= '0;
         for (int i = 0; i < 6; i++) begin
            state[i] <= IDLE;
            timer[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 6; i++) begin
            pulse_out[i] <= 1'b0;
            if (fall[i]) begin
               state[i] <= IDLE;
               timer[i] <= '0;
            end else begin
               case (state[i])
                  IDLE: begin
                     timer[i] <= '0;
                     if (rise[i]) begin
                        pulse_out[i] <= 1'b1;
                        state[i]     <= DELAY;
                     end
                  end
                  DELAY: begin
                     if (REPEAT_EN == 0) begin
                        timer[i] <= '0;
                     end else if (timer[i] == DLY_LAST) begin
                        pulse_out[i] <= 1'b1;
                        timer[i]     <= '0;
                        state[i]     <= REPEAT;
                     end else begin
                        timer[i] <= timer[i] + 1'b1;
                     end
                  end
                  REPEAT: begin
                     if (timer[i] == PER_LAST) begin
                        pulse_out[i] <= 1'b1;
                        timer[i]     <= '0;
                     end else begin
                        timer[i] <= timer[i] + 1'b1;
                     end
                  end
                  default: begin
                     state[i] <= IDLE;
                     timer[i] <= '0;
                  end
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_press <= 1'b0;
      end else begin
         any_press <= |pulse_out;
      end
   end

endmodule
